serial_fa_adder: RTL

//   Bit-serial WIDTH-bit adder controller. It sits directly upstream of a

---
 rtl/serial_fa_adder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/serial_fa_adder.sv
// -----------------------------------------------------------------------------
// serial_fa_adder
//   Bit-serial WIDTH-bit adder controller. It drives one external 1-bit full
//   adder LSB-first, one bit per clock. The adder's sum/carry are captured each
//   cycle, so that {cout,sum} = a + b + cin is built up over WIDTH cycles.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   start              add request, sampled only while idle
//   a, b, cin          operands and carry-in, captured when start is accepted
//   fa_a, fa_b, fa_cin drive the external full adder (all registered)
//   fa_sum, fa_carry   combinational results from the external full adder
//   busy               high while an add is in progress or being reported
//   done               one-cycle pulse: sum/cout are valid
//   sum, cout          result; held until the next accepted start
// -----------------------------------------------------------------------------
module serial_fa_adder #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Zeros shift in from the top, so the operand registers are
                // empty once the last bit has been consumed.
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                sum_d  = {fa_sum, sum_q[WIDTH-1:1]};
                if (cnt_q == LAST_BIT) begin
                    // Clearing the running carry here keeps fa_cin at 0
                    // outside RUN without any output gating.
                    cout_d  = fa_carry;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    c_d   = fa_carry;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // exactly with the state they describe.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Operand shift registers and the carry are zero outside RUN, so the
    // full-adder inputs come straight from flops.
    assign fa_a   = a_sh_q[0];
    assign fa_b   = b_sh_q[0];
    assign fa_cin = c_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign sum    = sum_q;
    assign cout   = cout_q;

endmodule
